// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared constants for the forward and inverse Fibonacci FSMD units
package fib_pkg;

    // FSM state encoding shared with the forward Fibonacci unit
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_OP   = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Default widths: fib(30) = 832040 is the largest term that fits 20 bits
    localparam int FIB_W       = 20;
    localparam int FIB_NW      = 5;
    localparam int FIB_MAX_IDX = 30;

endpackage

// File: rtl/fib_inverse.sv
// rtl/fib_inverse.sv - inverse Fibonacci FSMD (largest n with fib(n) <= v); FIB_INV_REM_EN adds rem output
module fib_inverse
    import fib_pkg::*;
#(
    parameter int W  = FIB_W,
    parameter int NW = FIB_NW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  v,
    output logic          ready,
    output logic          done_tick,
    output logic [NW-1:0] idx,
`ifdef FIB_INV_REM_EN
    output logic [W-1:0]  rem,
`endif
    output logic          exact
);

    logic [1:0]    r_state;
    logic [W-1:0]  r_t0;
    logic [W-1:0]  r_t1;
    logic [W-1:0]  r_vr;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_idx;
    logic          r_exact;
`ifdef FIB_INV_REM_EN
    logic [W-1:0]  r_rem;
`endif

    // Next term carries one extra bit so a term beyond 2^W-1 always exceeds vr
    logic [W:0]    w_nxt;
    logic          w_past;

    // Next-term adder and terminal comparison
    always_comb begin
        w_nxt  = {1'b0, r_t0} + {1'b0, r_t1};
        w_past = (w_nxt > {1'b0, r_vr});
    end

    // FSMD: state and data registers advance together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_t0    <= '0;
            r_t1    <= '0;
            r_vr    <= '0;
            r_n     <= '0;
            r_idx   <= '0;
            r_exact <= 1'b0;
`ifdef FIB_INV_REM_EN
            r_rem   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vr    <= v;
                        r_t0    <= '0;
                        r_t1    <= W'(1);
                        r_n     <= NW'(1);
                        r_state <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (r_vr == '0) begin
                        // fib(0) = 0 is the only term not reached by the search loop
                        r_idx   <= '0;
                        r_exact <= 1'b1;
`ifdef FIB_INV_REM_EN
                        r_rem   <= '0;
`endif
                        r_state <= ST_DONE;
                    end else if (w_past) begin
                        // t1 = fib(n) is the last term not above vr; n grows past the
                        // fib(1)=fib(2) tie so v=1 reports index 2
                        r_idx   <= r_n;
                        r_exact <= (r_t1 == r_vr);
`ifdef FIB_INV_REM_EN
                        r_rem   <= r_vr - r_t1;
`endif
                        r_state <= ST_DONE;
                    end else begin
                        r_t0 <= r_t1;
                        r_t1 <= w_nxt[W-1:0];
                        r_n  <= r_n + NW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state; results come straight from their registers
    always_comb begin
        ready     = (r_state == ST_IDLE);
        done_tick = (r_state == ST_DONE);
        idx       = r_idx;
        exact     = r_exact;
`ifdef FIB_INV_REM_EN
        rem       = r_rem;
`endif
    end

endmodule

// File: tb/tb_fib_inverse.sv
// tb/tb_fib_inverse.sv - scoreboard testbench for fib_inverse
module tb_fib_inverse;
    import fib_pkg::*;

    localparam int W  = FIB_W;
    localparam int NW = FIB_NW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  v;
    logic          ready;
    logic          done_tick;
    logic [NW-1:0] idx;
    logic          exact;
`ifdef FIB_INV_REM_EN
    logic [W-1:0]  rem;
`endif

    fib_inverse #(.W(W), .NW(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .v         (v),
        .ready     (ready),
        .done_tick (done_tick),
        .idx       (idx),
`ifdef FIB_INV_REM_EN
        .rem       (rem),
`endif
        .exact     (exact)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e_idx;
        int e_exact;
        int e_rem;
        int e_lat;
        int s_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   n_runs    = 0;
    int   n_done    = 0;
    bit   prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic void model(input int val, output int n, output int ex, output int rm);
        longint f[0:31];
        f[0] = 0;
        f[1] = 1;
        for (int i = 2; i < 32; i++) f[i] = f[i-1] + f[i-2];
        n = 0;
        for (int i = 0; i < 32; i++) if (f[i] <= longint'(val)) n = i;
        ex = (f[n] == longint'(val)) ? 1 : 0;
        rm = val - int'(f[n]);
    endfunction

    function automatic exp_t mk(input int e_idx, input int e_ex, input int e_rem, input int s);
        exp_t e;
        e.e_idx   = e_idx;
        e.e_exact = e_ex;
        e.e_rem   = e_rem;
        e.e_lat   = ((e_idx > 1) ? e_idx : 1) + 1;
        e.s_cyc   = s;
        return e;
    endfunction

    // Wait for idle, present one start pulse, record the expected result
    task automatic issue(input int val, input int e_idx, input int e_ex, input int e_rem);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_timeout", 0, 1);
        start = 1'b1;
        v     = W'(val);
        sb.push_back(mk(e_idx, e_ex, e_rem, cyc));
        n_runs++;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: compare each completed run against the head of the scoreboard
    always @(negedge clk) begin
        if (done_tick) begin
            exp_t e;
            n_done++;
            check("ready_with_done", int'(ready), 0);
            if (prev_done) check("done_pulse_width", 2, 1);
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("idx", int'(idx), e.e_idx);
                check("exact", int'(exact), e.e_exact);
`ifdef FIB_INV_REM_EN
                check("rem", int'(rem), e.e_rem);
`endif
                check("latency", cyc - e.s_cyc, e.e_lat);
            end
        end
        prev_done = done_tick;
    end

    initial begin
        int n, ex, rm, w, rv;
        reset = 1'b1;
        start = 1'b0;
        v     = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done_tick), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_exact", int'(exact), 0);
        reset = 1'b0;

        // Directed vectors
        issue(0, 0, 1, 0);
        issue(1, 2, 1, 0);
        issue(100, 11, 0, 11);
        issue(832040, 30, 1, 0);
        issue(20'hFFFFF, 30, 0, 216535);

        // start while busy is ignored
        issue(100, 11, 0, 11);
        repeat (3) @(negedge clk);
        check("busy_ready_low", int'(ready), 0);
        start = 1'b1;
        v     = W'(5);
        @(negedge clk);
        start = 1'b0;

        // start held through done: second run starts in the following idle cycle
        issue(13, 7, 1, 0);
        start = 1'b1;
        v     = W'(13);
        w = 0;
        while (!done_tick && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!done_tick) check("held_done_timeout", 0, 1);
        sb.push_back(mk(7, 1, 0, cyc + 1));
        n_runs++;
        @(negedge clk);
        check("idle_after_done", int'(ready), 1);
        @(negedge clk);
        start = 1'b0;

        // Reset mid-operation
        issue(832040, 30, 1, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_idx", int'(idx), 0);
        check("midrst_exact", int'(exact), 0);
        void'(sb.pop_back());
        n_runs--;
        @(negedge clk);
        reset = 1'b0;
        issue(8, 6, 1, 0);

        // Random values against the reference model
        for (int k = 0; k < 10; k++) begin
            rv = int'($urandom_range(0, 20'hFFFFF));
            model(rv, n, ex, rm);
            issue(rv, n, ex, rm);
        end

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_scoreboard", sb.size(), 0);
        repeat (5) @(negedge clk);
        check("done_count", n_done, n_runs);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
